// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit
// Description : Instruction-fetch stage that sits beside the control state
//               machine. It holds the program counter and a two-byte
//               instruction register, and drives the memory byte address.
//               Strobes arrive registered on the negative edge and are acted
//               on at the positive edge of clk.
//
// Ports       : clk, rst_n                 clock, async active-low reset
//               rd, load_ir, incr_pc,      control strobes from the state
//               load_pc, halt              machine
//               data_in [7:0]              memory byte (combinational from addr)
//               opcode  [2:0]              top three IR bits
//               ir_addr [ADDR_W-1:0]       IR operand field
//               pc_addr [ADDR_W-1:0]       current program counter
//               addr    [ADDR_W-1:0]       memory byte address
//               fetch                      high while an IR byte is being fetched
//               ir_valid                   one-cycle pulse after the low byte lands
//               halted                     sticky halt status
//               brk_addr, brk_hit          only with FETCH_BREAKPOINT_EN
//
// Options     : FETCH_BREAKPOINT_EN - adds a PC breakpoint that halts the
//               stage before the high byte at brk_addr is captured.
//
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit #(
    parameter int                ADDR_W   = 13,
    parameter logic [ADDR_W-1:0] PC_RESET = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rd,
    input  logic              load_ir,
    input  logic              incr_pc,
    input  logic              load_pc,
    input  logic              halt,
    input  logic [7:0]        data_in,
    output logic [2:0]        opcode,
    output logic [ADDR_W-1:0] ir_addr,
    output logic [ADDR_W-1:0] pc_addr,
    output logic [ADDR_W-1:0] addr,
    output logic              fetch,
    output logic              ir_valid,
    output logic              halted
`ifdef FETCH_BREAKPOINT_EN
    ,
    input  logic [ADDR_W-1:0] brk_addr,
    output logic              brk_hit
`endif
);

    localparam int                c_IR_W   = ADDR_W + 3;
    localparam logic [ADDR_W-1:0] c_PC_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    logic [ADDR_W-1:0] r_pc;
    logic [c_IR_W-1:0] r_ir;
    logic              r_byte_sel;
    logic              r_ir_valid;
    logic              r_halted;

    logic              w_capture;
    logic              w_brk;
    logic [ADDR_W-1:0] w_fetch_addr;

    // byte_sel selects the low byte at pc+1; the add wraps naturally.
    assign w_fetch_addr = r_pc + {{(ADDR_W-1){1'b0}}, r_byte_sel};
    assign w_capture    = load_ir & rd & ~r_halted;

`ifdef FETCH_BREAKPOINT_EN
    logic r_brk_hit;

    // Breakpoint fires at the start of an instruction (high-byte fetch).
    assign w_brk = w_capture & ~r_byte_sel & (r_pc == brk_addr);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_brk_hit <= 1'b0;
        end else if (w_brk) begin
            r_brk_hit <= 1'b1;
        end
    end

    assign brk_hit = r_brk_hit;
`else
    assign w_brk = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc       <= PC_RESET;
            r_ir       <= '0;
            r_byte_sel <= 1'b0;
            r_ir_valid <= 1'b0;
            r_halted   <= 1'b0;
        end else begin
            r_ir_valid <= 1'b0;
            // Halt is sampled regardless of state; freezing uses the
            // pre-edge status so the halting cycle's strobes still apply.
            if (halt) begin
                r_halted <= 1'b1;
            end
            if (!r_halted) begin
                if (w_brk) begin
                    r_halted <= 1'b1;
                end else if (w_capture) begin
                    if (!r_byte_sel) begin
                        r_ir[c_IR_W-1 -: 8] <= data_in;
                        r_byte_sel          <= 1'b1;
                    end else begin
                        r_ir[7:0]  <= data_in;
                        r_byte_sel <= 1'b0;
                        r_ir_valid <= 1'b1;
                    end
                end else if (!load_ir) begin
                    // Any gap in load_ir realigns to the high byte.
                    r_byte_sel <= 1'b0;
                end

                // Jump target is the operand currently in the IR (pre-edge).
                if (load_pc) begin
                    r_pc <= r_ir[ADDR_W-1:0];
                end else if (incr_pc) begin
                    r_pc <= r_pc + c_PC_ONE;
                end
            end
        end
    end

    assign opcode   = r_ir[c_IR_W-1 -: 3];
    assign ir_addr  = r_ir[ADDR_W-1:0];
    assign pc_addr  = r_pc;
    assign fetch    = load_ir;
    assign addr     = load_ir ? w_fetch_addr : r_ir[ADDR_W-1:0];
    assign ir_valid = r_ir_valid;
    assign halted   = r_halted;

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_unit
// Description : Self-checking bench for fetch_unit. A behavioural model of
//               the PC / IR / byte pointer is advanced alongside the DUT;
//               directed scenarios are followed by randomized strobes.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

    localparam int AW    = 13;
    localparam int MEMSZ = 8192;

    logic          clk     = 1'b0;
    logic          rst_n   = 1'b0;
    logic          rd      = 1'b0;
    logic          load_ir = 1'b0;
    logic          incr_pc = 1'b0;
    logic          load_pc = 1'b0;
    logic          halt    = 1'b0;
    logic [7:0]    data_in;
    logic [2:0]    opcode;
    logic [AW-1:0] ir_addr;
    logic [AW-1:0] pc_addr;
    logic [AW-1:0] addr;
    logic          fetch;
    logic          ir_valid;
    logic          halted;
`ifdef FETCH_BREAKPOINT_EN
    logic [AW-1:0] brk_addr = 13'h1ABC;
    logic          brk_hit;
`endif

    logic [7:0] mem [0:MEMSZ-1];
    assign data_in = mem[addr];

    fetch_unit #(.ADDR_W(AW), .PC_RESET('0)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rd       (rd),
        .load_ir  (load_ir),
        .incr_pc  (incr_pc),
        .load_pc  (load_pc),
        .halt     (halt),
        .data_in  (data_in),
        .opcode   (opcode),
        .ir_addr  (ir_addr),
        .pc_addr  (pc_addr),
        .addr     (addr),
        .fetch    (fetch),
        .ir_valid (ir_valid),
        .halted   (halted)
`ifdef FETCH_BREAKPOINT_EN
        ,
        .brk_addr (brk_addr),
        .brk_hit  (brk_hit)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    int          m_pc;
    logic [15:0] m_ir;
    int          m_bsel;
    bit          m_valid;
    bit          m_halted;
    bit          m_brk;
    int          e_addr;      // expected address for the current step
    logic [AW-1:0] s_addr;    // DUT address sampled during the current step

    task automatic m_reset();
        m_pc = 0; m_ir = 16'h0000; m_bsel = 0;
        m_valid = 1'b0; m_halted = 1'b0; m_brk = 1'b0;
    endtask

    // Apply one cycle of strobes, sample addr before the edge, advance model,
    // then return #1 after the active edge.
    task automatic step(input bit r, input bit l, input bit i, input bit p, input bit h);
        int  operand;
        bit  brk;
        bit  new_halt;
        rd = r; load_ir = l; incr_pc = i; load_pc = p; halt = h;
        #1;
        s_addr  = addr;
        e_addr  = l ? (m_pc + m_bsel) % MEMSZ : int'(m_ir[12:0]);
        operand = int'(m_ir[12:0]);
        brk      = 1'b0;
        new_halt = h;
        m_valid  = 1'b0;
        if (!m_halted) begin
`ifdef FETCH_BREAKPOINT_EN
            brk = l && r && (m_bsel == 0) && (m_pc == int'(brk_addr));
`endif
            if (brk) begin
                m_brk    = 1'b1;
                new_halt = 1'b1;
            end else if (l && r) begin
                if (m_bsel == 0) begin
                    m_ir[15:8] = mem[e_addr];
                    m_bsel     = 1;
                end else begin
                    m_ir[7:0] = mem[e_addr];
                    m_bsel    = 0;
                    m_valid   = 1'b1;
                end
            end else if (!l) begin
                m_bsel = 0;
            end
            if (p)      m_pc = operand;
            else if (i) m_pc = (m_pc + 1) % MEMSZ;
        end
        m_halted = m_halted | new_halt;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rd = 0; load_ir = 0; incr_pc = 0; load_pc = 0; halt = 0;
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        m_reset();
        @(posedge clk);
        #1;
    endtask

    // S1..S4 of the instruction cycle, optional halt on S4, then S5..S8 idle
    task automatic fetch_instr(input bit halt_s4);
        step(1, 1, 0, 0, 0);
        step(1, 1, 1, 0, 0);
        step(0, 0, 0, 0, 0);
        step(0, 0, 1, 0, halt_s4);
        for (int k = 0; k < 4; k++) step(0, 0, 0, 0, 0);
    endtask

    task automatic test_reset();
        do_reset();
        mem[0] = 8'hA0; mem[1] = 8'h05;
        step(1, 1, 0, 0, 0);
        step(1, 1, 1, 0, 0);
        step(0, 0, 0, 0, 1);          // halted, pc=1, ir=A005
        rd = 0; load_ir = 0; incr_pc = 0; load_pc = 0; halt = 0;
        #2;
        rst_n = 1'b0;                  // mid-cycle, away from any edge
        #1;
        n_checks++;
        if (pc_addr !== 13'h0000) begin n_fail++; $display("FAIL reset_pc: got %h want 0000", pc_addr); end
        n_checks++;
        if ({opcode, ir_addr} !== 16'h0000) begin n_fail++; $display("FAIL reset_ir: got %h want 0000", {opcode, ir_addr}); end
        n_checks++;
        if (halted !== 1'b0 || ir_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_flags: halted=%b ir_valid=%b want 0 0", halted, ir_valid);
        end
        m_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_fetch();
        do_reset();
        mem[0] = 8'hA0; mem[1] = 8'h05;
        step(1, 1, 0, 0, 0);
        n_checks++;
        if (s_addr !== 13'h0000) begin n_fail++; $display("FAIL fetch_s1_addr: got %h want 0000", s_addr); end
        step(1, 1, 1, 0, 0);
        n_checks++;
        if (s_addr !== 13'h0001) begin n_fail++; $display("FAIL fetch_s2_addr: got %h want 0001", s_addr); end
        n_checks++;
        if (ir_valid !== 1'b1) begin n_fail++; $display("FAIL fetch_valid_pulse: got %b want 1", ir_valid); end
        step(0, 0, 0, 0, 0);
        n_checks++;
        if (ir_valid !== 1'b0) begin n_fail++; $display("FAIL fetch_valid_end: got %b want 0", ir_valid); end
        n_checks++;
        if (opcode !== 3'b101 || ir_addr !== 13'h0005) begin
            n_fail++; $display("FAIL fetch_ir: got op=%b addr=%h want 101 0005", opcode, ir_addr);
        end
        step(0, 0, 1, 0, 0);
        n_checks++;
        if (pc_addr !== 13'h0002) begin n_fail++; $display("FAIL fetch_pc: got %h want 0002", pc_addr); end
        step(0, 0, 0, 0, 0);
        n_checks++;
        if (s_addr !== 13'h0005) begin n_fail++; $display("FAIL operand_addr: got %h want 0005", s_addr); end
        for (int k = 0; k < 3; k++) step(0, 0, 0, 0, 0);
    endtask

    task automatic test_jump();
        // Continues from test_fetch: pc=2
        mem[2] = 8'hE0; mem[3] = 8'h40;
        step(1, 1, 0, 0, 0);
        step(1, 1, 1, 0, 0);
        step(0, 0, 0, 0, 0);
        step(0, 0, 1, 1, 0);           // load_pc wins over incr_pc
        n_checks++;
        if (pc_addr !== 13'h0040) begin n_fail++; $display("FAIL jump_pc: got %h want 0040", pc_addr); end
    endtask

    task automatic test_wrap();
        // Continues from test_jump: pc=0x40
        mem[13'h0040] = 8'h1F; mem[13'h0041] = 8'hFF;
        step(1, 1, 0, 0, 0);
        step(1, 1, 1, 0, 0);
        step(0, 0, 0, 1, 0);
        n_checks++;
        if (pc_addr !== 13'h1FFF) begin n_fail++; $display("FAIL wrap_load: got %h want 1fff", pc_addr); end
        mem[13'h1FFF] = 8'h62; mem[0] = 8'h34;
        step(1, 1, 0, 0, 0);
        step(1, 1, 1, 0, 0);
        n_checks++;
        if (s_addr !== 13'h0000) begin n_fail++; $display("FAIL wrap_addr: got %h want 0000", s_addr); end
        n_checks++;
        if (pc_addr !== 13'h0000) begin n_fail++; $display("FAIL wrap_pc: got %h want 0000", pc_addr); end
        n_checks++;
        if ({opcode, ir_addr} !== 16'h6234) begin n_fail++; $display("FAIL wrap_ir: got %h want 6234", {opcode, ir_addr}); end
    endtask

    task automatic test_halt();
        bit ok_valid;
        do_reset();
        mem[0] = 8'h00; mem[1] = 8'h00; mem[2] = 8'h00; mem[3] = 8'h00;
        mem[4] = 8'h1A; mem[5] = 8'hBC;
        fetch_instr(0);
        fetch_instr(0);
        fetch_instr(1);
        n_checks++;
        if (halted !== 1'b1 || pc_addr !== 13'h0006) begin
            n_fail++; $display("FAIL halt_entry: halted=%b pc=%h want 1 0006", halted, pc_addr);
        end
        ok_valid = 1'b1;
        for (int k = 0; k < 20; k++) begin
            step(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
            if (ir_valid !== 1'b0) ok_valid = 1'b0;
        end
        n_checks++;
        if (pc_addr !== 13'h0006 || {opcode, ir_addr} !== 16'h1ABC) begin
            n_fail++; $display("FAIL halt_frozen: pc=%h ir=%h want 0006 1abc", pc_addr, {opcode, ir_addr});
        end
        n_checks++;
        if (!ok_valid || halted !== 1'b1) begin
            n_fail++; $display("FAIL halt_sticky: valid_quiet=%b halted=%b want 1 1", ok_valid, halted);
        end
        do_reset();
        n_checks++;
        if (halted !== 1'b0) begin n_fail++; $display("FAIL halt_clear: got %b want 0", halted); end
    endtask

`ifdef FETCH_BREAKPOINT_EN
    task automatic test_breakpoint();
        brk_addr = 13'h0004;
        do_reset();
        mem[0] = 8'h00; mem[1] = 8'h11; mem[2] = 8'h23; mem[3] = 8'h45;
        mem[4] = 8'hFF; mem[5] = 8'hFF;
        fetch_instr(0);
        fetch_instr(0);
        n_checks++;
        if (brk_hit !== 1'b0) begin n_fail++; $display("FAIL brk_early: got %b want 0", brk_hit); end
        step(1, 1, 0, 0, 0);
        n_checks++;
        if (brk_hit !== 1'b1 || halted !== 1'b1 || pc_addr !== 13'h0004) begin
            n_fail++; $display("FAIL brk_hit: brk=%b halted=%b pc=%h want 1 1 0004", brk_hit, halted, pc_addr);
        end
        n_checks++;
        if ({opcode, ir_addr} !== 16'h2345) begin n_fail++; $display("FAIL brk_ir: got %h want 2345", {opcode, ir_addr}); end
        brk_addr = 13'h1ABC;
    endtask
`endif

    task automatic test_random();
        do_reset();
        for (int a = 0; a < MEMSZ; a++) mem[a] = 8'($urandom);
        for (int k = 0; k < 400; k++) begin
            if (m_halted && ($urandom % 8 == 0)) do_reset();
            step(($urandom % 4) != 0, 1'($urandom), ($urandom % 3) == 0,
                 ($urandom % 8) == 0, ($urandom % 100) == 0);
            n_checks++;
            if (s_addr !== AW'(e_addr)) begin n_fail++; $display("FAIL rnd_addr[%0d]: got %h want %h", k, s_addr, AW'(e_addr)); end
            n_checks++;
            if (pc_addr !== AW'(m_pc)) begin n_fail++; $display("FAIL rnd_pc[%0d]: got %h want %h", k, pc_addr, AW'(m_pc)); end
            n_checks++;
            if ({opcode, ir_addr} !== m_ir) begin n_fail++; $display("FAIL rnd_ir[%0d]: got %h want %h", k, {opcode, ir_addr}, m_ir); end
            n_checks++;
            if (ir_valid !== m_valid || halted !== m_halted) begin
                n_fail++; $display("FAIL rnd_flags[%0d]: valid=%b halted=%b want %b %b", k, ir_valid, halted, m_valid, m_halted);
            end
            n_checks++;
            if (fetch !== load_ir) begin n_fail++; $display("FAIL rnd_fetch[%0d]: got %b want %b", k, fetch, load_ir); end
        end
    endtask

    initial begin
        for (int a = 0; a < MEMSZ; a++) mem[a] = 8'h00;
        m_reset();
        test_reset();
        test_fetch();
        test_jump();
        test_wrap();
        test_halt();
`ifdef FETCH_BREAKPOINT_EN
        test_breakpoint();
`endif
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
